// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the machine word and the data-memory responder state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } dmem_state_t;

    typedef enum logic {
        KIND_READ,
        KIND_WRITE
    } dmem_kind_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage with asynchronous clear, one write port and one
// registered read port whose output holds until the next read.
module dmem_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  word_t                    wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output word_t                    rdata_o
);

    word_t mem_q [DEPTH];
    word_t rdata_q;

    // NOTE: every word is cleared on reset, so this array maps to flops rather than RAM macros.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the pipeline data port: accepts dREN/dWEN, waits LAT cycles,
// then pulses dhit for one cycle with read data or commits the write.
module dmem_responder
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t daddr,
    input  word_t dmemstore,
    output word_t dmemload,
    output logic  dhit,
    output logic  busy
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    dmem_state_t      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    word_t            data_q, data_d;
    dmem_kind_t       kind_q, kind_d;

    logic             req;
    logic             abort;
    logic [IDX_W-1:0] cur_idx;
    dmem_kind_t       cur_kind;
    logic             arr_we;
    logic             arr_re;
    logic [IDX_W-1:0] arr_ridx;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{daddr[31:IDX_W+2], daddr[1:0]};

    assign req      = dREN | dWEN;
    assign cur_idx  = daddr[IDX_W+1:2];
    assign cur_kind = dWEN ? KIND_WRITE : KIND_READ;

    // Any drift of the held request from what was accepted cancels the access.
    assign abort = !req
                || (cur_idx != idx_q)
                || (cur_kind != kind_q)
                || ((kind_q == KIND_WRITE) && (dmemstore != data_q));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        kind_d   = kind_q;
        dhit     = 1'b0;
        busy     = 1'b0;
        arr_we   = 1'b0;
        arr_re   = 1'b0;
        arr_ridx = idx_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d  = cur_idx;
                    data_d = dmemstore;
                    kind_d = cur_kind;
                    if (LAT == 0) begin
                        state_d  = ACK;
                        arr_re   = (cur_kind == KIND_READ);
                        arr_ridx = cur_idx;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ACK;
                    arr_re  = (kind_q == KIND_READ);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                dhit    = 1'b1;
                busy    = 1'b1;
                arr_we  = (kind_q == KIND_WRITE);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            kind_q  <= KIND_READ;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            kind_q  <= kind_d;
        end
    end

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .CLK    (CLK),
        .nRST   (nRST),
        .we_i   (arr_we),
        .waddr_i(idx_q),
        .wdata_i(data_q),
        .re_i   (arr_re),
        .raddr_i(arr_ridx),
        .rdata_o(dmemload)
    );

endmodule
